riscv_ppreg_skid: RTL and testbench

//  Parametrised pipeline-stage register with valid/ready handshake, replacing fixed enable-stalled stage regs.

---
 rtl/riscv_ppreg_skid.sv | 165 ++++++++++++++++
 tb/tb_riscv_ppreg_skid.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_ppreg_skid.sv
// riscv_ppreg_skid: pipeline-stage register with valid/ready handshake.
// Holds one entry (SKID=0) or up to two entries (SKID=1, main + skid) so
// that ready_in can be driven from a flop without losing throughput.
// Also provides flush with control kill, a retire pulse and a saturating
// stall-cycle counter.
module riscv_ppreg_skid #(
  parameter int DATA_W  = 64,
  parameter int CTRL_W  = 16,
  parameter int SKID    = 1,
  parameter int STALL_W = 16
) (
  input  logic               i_riscv_pps_clk,
  input  logic               i_riscv_pps_rst_n,
  input  logic               i_riscv_pps_flush,
  input  logic               i_riscv_pps_valid_in,
  output logic               o_riscv_pps_ready_in,
  input  logic [DATA_W-1:0]  i_riscv_pps_data_in,
  input  logic [CTRL_W-1:0]  i_riscv_pps_ctrl_in,
  output logic               o_riscv_pps_valid_out,
  input  logic               i_riscv_pps_ready_out,
  output logic [DATA_W-1:0]  o_riscv_pps_data_out,
  output logic [CTRL_W-1:0]  o_riscv_pps_ctrl_out,
  output logic               o_riscv_pps_retire,
  output logic [1:0]         o_riscv_pps_count,
  output logic [STALL_W-1:0] o_riscv_pps_stall_cnt
);

  // State encoding doubles as the occupancy count.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_e;

  localparam logic [STALL_W-1:0] STALL_MAX = {STALL_W{1'b1}};

  state_e             state_q, state_d;
  logic [DATA_W-1:0]  main_data_q, main_data_d;
  logic [CTRL_W-1:0]  main_ctrl_q, main_ctrl_d;
  logic [DATA_W-1:0]  skid_data_q, skid_data_d;
  logic [CTRL_W-1:0]  skid_ctrl_q, skid_ctrl_d;
  logic               retire_q, retire_d;
  logic               ready_q, ready_d;
  logic [STALL_W-1:0] stall_q, stall_d;

  logic valid_out;
  logic ready_in;
  logic in_hs;
  logic out_hs;

  assign valid_out = (state_q != ST_EMPTY);
  // Without skid storage ready must look through to the consumer; with it,
  // ready comes straight from a flop to cut the combinational path.
  assign ready_in  = (SKID != 0) ? ready_q
                                 : (!valid_out || i_riscv_pps_ready_out);
  assign in_hs     = i_riscv_pps_valid_in && ready_in;
  assign out_hs    = valid_out && i_riscv_pps_ready_out;

  // Next-state and datapath selection; flush kills every held entry.
  always_comb begin
    state_d     = state_q;
    main_data_d = main_data_q;
    main_ctrl_d = main_ctrl_q;
    skid_data_d = skid_data_q;
    skid_ctrl_d = skid_ctrl_q;
    if (i_riscv_pps_flush) begin
      state_d     = ST_EMPTY;
      main_data_d = '0;
      main_ctrl_d = '0;
      skid_data_d = '0;
      skid_ctrl_d = '0;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_hs) begin
            state_d     = ST_ONE;
            main_data_d = i_riscv_pps_data_in;
            main_ctrl_d = i_riscv_pps_ctrl_in;
          end else begin
            state_d = ST_EMPTY;
          end
        end
        ST_ONE: begin
          if (in_hs && out_hs) begin
            state_d     = ST_ONE;
            main_data_d = i_riscv_pps_data_in;
            main_ctrl_d = i_riscv_pps_ctrl_in;
          end else if (in_hs) begin
            // Only reachable with skid storage: consumer stalled, park the new entry.
            if (SKID != 0) begin
              state_d     = ST_TWO;
              skid_data_d = i_riscv_pps_data_in;
              skid_ctrl_d = i_riscv_pps_ctrl_in;
            end else begin
              state_d     = ST_ONE;
              main_data_d = i_riscv_pps_data_in;
              main_ctrl_d = i_riscv_pps_ctrl_in;
            end
          end else if (out_hs) begin
            state_d = ST_EMPTY;
          end else begin
            state_d = ST_ONE;
          end
        end
        ST_TWO: begin
          // ready_in is low here, so only the drain side can move.
          if (out_hs) begin
            state_d     = ST_ONE;
            main_data_d = skid_data_q;
            main_ctrl_d = skid_ctrl_q;
          end else begin
            state_d = ST_TWO;
          end
        end
        default: begin
          state_d = ST_EMPTY;
        end
      endcase
    end
  end

  // Registered ready, retire pulse and saturating stall counter.
  always_comb begin
    ready_d  = (state_d != ST_TWO);
    retire_d = out_hs && !i_riscv_pps_flush;
    if (valid_out && !i_riscv_pps_ready_out && !i_riscv_pps_flush &&
        (stall_q != STALL_MAX)) begin
      stall_d = stall_q + STALL_W'(1);
    end else begin
      stall_d = stall_q;
    end
  end

  // State and storage flops with synchronous active-low reset.
  always_ff @(posedge i_riscv_pps_clk) begin
    if (!i_riscv_pps_rst_n) begin
      state_q     <= ST_EMPTY;
      main_data_q <= '0;
      main_ctrl_q <= '0;
      skid_data_q <= '0;
      skid_ctrl_q <= '0;
      retire_q    <= 1'b0;
      ready_q     <= 1'b1;
      stall_q     <= '0;
    end else begin
      state_q     <= state_d;
      main_data_q <= main_data_d;
      main_ctrl_q <= main_ctrl_d;
      skid_data_q <= skid_data_d;
      skid_ctrl_q <= skid_ctrl_d;
      retire_q    <= retire_d;
      ready_q     <= ready_d;
      stall_q     <= stall_d;
    end
  end

  assign o_riscv_pps_ready_in  = ready_in;
  assign o_riscv_pps_valid_out = valid_out;
  assign o_riscv_pps_data_out  = main_data_q;
  assign o_riscv_pps_ctrl_out  = valid_out ? main_ctrl_q : {CTRL_W{1'b0}};
  assign o_riscv_pps_retire    = retire_q;
  assign o_riscv_pps_count     = state_q;
  assign o_riscv_pps_stall_cnt = stall_q;

endmodule

// File: tb/tb_riscv_ppreg_skid.sv
// Directed bench for riscv_ppreg_skid: three instances (SKID=1 default,
// SKID=0, SKID=1 with a 4-bit stall counter) share clock and reset.
module tb_riscv_ppreg_skid;

  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  // Instance A: SKID=1, STALL_W=16
  logic fl_a, va, rdy_a, vo_a, rdo_a, ret_a;
  logic [63:0] da, do_a;
  logic [15:0] ca, co_a, st_a;
  logic [1:0]  cnt_a;
  // Instance B: SKID=0
  logic fl_b, vb, rdy_b, vo_b, rdo_b, ret_b;
  logic [63:0] db, do_b;
  logic [15:0] cb, co_b, st_b;
  logic [1:0]  cnt_b;
  // Instance C: SKID=1, STALL_W=4
  logic fl_c, vc, rdy_c, vo_c, rdo_c, ret_c;
  logic [63:0] dc, do_c;
  logic [15:0] cc, co_c;
  logic [3:0]  st_c;
  logic [1:0]  cnt_c;

  riscv_ppreg_skid #(.DATA_W(64), .CTRL_W(16), .SKID(1), .STALL_W(16)) u_a (
    .i_riscv_pps_clk(clk), .i_riscv_pps_rst_n(rst_n), .i_riscv_pps_flush(fl_a),
    .i_riscv_pps_valid_in(va), .o_riscv_pps_ready_in(rdy_a),
    .i_riscv_pps_data_in(da), .i_riscv_pps_ctrl_in(ca),
    .o_riscv_pps_valid_out(vo_a), .i_riscv_pps_ready_out(rdo_a),
    .o_riscv_pps_data_out(do_a), .o_riscv_pps_ctrl_out(co_a),
    .o_riscv_pps_retire(ret_a), .o_riscv_pps_count(cnt_a),
    .o_riscv_pps_stall_cnt(st_a));

  riscv_ppreg_skid #(.DATA_W(64), .CTRL_W(16), .SKID(0), .STALL_W(16)) u_b (
    .i_riscv_pps_clk(clk), .i_riscv_pps_rst_n(rst_n), .i_riscv_pps_flush(fl_b),
    .i_riscv_pps_valid_in(vb), .o_riscv_pps_ready_in(rdy_b),
    .i_riscv_pps_data_in(db), .i_riscv_pps_ctrl_in(cb),
    .o_riscv_pps_valid_out(vo_b), .i_riscv_pps_ready_out(rdo_b),
    .o_riscv_pps_data_out(do_b), .o_riscv_pps_ctrl_out(co_b),
    .o_riscv_pps_retire(ret_b), .o_riscv_pps_count(cnt_b),
    .o_riscv_pps_stall_cnt(st_b));

  riscv_ppreg_skid #(.DATA_W(64), .CTRL_W(16), .SKID(1), .STALL_W(4)) u_c (
    .i_riscv_pps_clk(clk), .i_riscv_pps_rst_n(rst_n), .i_riscv_pps_flush(fl_c),
    .i_riscv_pps_valid_in(vc), .o_riscv_pps_ready_in(rdy_c),
    .i_riscv_pps_data_in(dc), .i_riscv_pps_ctrl_in(cc),
    .o_riscv_pps_valid_out(vo_c), .i_riscv_pps_ready_out(rdo_c),
    .o_riscv_pps_data_out(do_c), .o_riscv_pps_ctrl_out(co_c),
    .o_riscv_pps_retire(ret_c), .o_riscv_pps_count(cnt_c),
    .o_riscv_pps_stall_cnt(st_c));

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  int ret_sum;

  initial begin
    rst_n = 1'b0;
    fl_a = 1'b0; va = 1'b1; da = 64'hDEAD; ca = 16'hFFFF; rdo_a = 1'b0;
    fl_b = 1'b0; vb = 1'b0; db = 64'h0;    cb = 16'h0;    rdo_b = 1'b1;
    fl_c = 1'b0; vc = 1'b0; dc = 64'h0;    cc = 16'h0;    rdo_c = 1'b0;

    // 1. Reset held two cycles while valid_in=1
    tick();
    tick();
    check("rst_valid_out", {63'd0, vo_a}, 64'd0);
    check("rst_count", {62'd0, cnt_a}, 64'd0);
    check("rst_ctrl_out", {48'd0, co_a}, 64'd0);
    check("rst_ready_in", {63'd0, rdy_a}, 64'd1);
    check("rst_retire", {63'd0, ret_a}, 64'd0);
    check("rst_stall", {48'd0, st_a}, 64'd0);
    rst_n = 1'b1; va = 1'b0; rdo_a = 1'b1;
    tick();
    check("post_rst_empty", {63'd0, vo_a}, 64'd0);

    // 2. Streaming 8 entries with ready_out=1
    ret_sum = 0;
    for (int i = 0; i <= 10; i++) begin
      if (i != 0) tick();
      if (i >= 1 && i <= 8) begin
        check("stream_valid", {63'd0, vo_a}, 64'd1);
        check("stream_data", do_a, 64'(i - 1));
        check("stream_ctrl", {48'd0, co_a}, 64'h100 | 64'(i - 1));
        check("stream_ready", {63'd0, rdy_a}, 64'd1);
      end
      ret_sum += int'(ret_a);
      if (i < 8) begin
        va = 1'b1; da = 64'(i); ca = 16'h100 | 16'(i);
      end else begin
        va = 1'b0;
      end
    end
    check("stream_retires", 64'(ret_sum), 64'd8);
    check("stream_end_empty", {62'd0, cnt_a}, 64'd0);

    // 3. Backpressure into the skid entry
    va = 1'b1; da = 64'h20; ca = 16'hA0; rdo_a = 1'b1;
    tick();
    check("bp_one_data", do_a, 64'h20);
    check("bp_one_count", {62'd0, cnt_a}, 64'd1);
    da = 64'h21; ca = 16'hA1; rdo_a = 1'b0;
    tick();
    check("bp_two_count", {62'd0, cnt_a}, 64'd2);
    check("bp_two_ready", {63'd0, rdy_a}, 64'd0);
    check("bp_frozen_data1", do_a, 64'h20);
    check("bp_stall1", {48'd0, st_a}, 64'd1);
    da = 64'h22; ca = 16'hA2;
    tick();
    check("bp_frozen_data2", do_a, 64'h20);
    check("bp_frozen_ctrl2", {48'd0, co_a}, 64'hA0);
    check("bp_stall2", {48'd0, st_a}, 64'd2);
    tick();
    check("bp_stall3", {48'd0, st_a}, 64'd3);
    check("bp_still_two", {62'd0, cnt_a}, 64'd2);
    rdo_a = 1'b1;
    tick();
    check("bp_drain_data1", do_a, 64'h21);
    check("bp_drain_count1", {62'd0, cnt_a}, 64'd1);
    check("bp_drain_ready1", {63'd0, rdy_a}, 64'd1);
    check("bp_drain_ret1", {63'd0, ret_a}, 64'd1);
    check("bp_stall_hold", {48'd0, st_a}, 64'd3);
    tick();
    check("bp_drain_data2", do_a, 64'h22);
    check("bp_drain_ctrl2", {48'd0, co_a}, 64'hA2);
    check("bp_drain_ret2", {63'd0, ret_a}, 64'd1);
    va = 1'b0;
    tick();
    check("bp_empty_valid", {63'd0, vo_a}, 64'd0);
    check("bp_empty_ctrl_gated", {48'd0, co_a}, 64'd0);
    check("bp_last_ret", {63'd0, ret_a}, 64'd1);
    tick();
    check("bp_ret_single", {63'd0, ret_a}, 64'd0);

    // 4. Flush while holding two entries
    va = 1'b1; da = 64'h30; ca = 16'hB0; rdo_a = 1'b0;
    tick();
    check("fl_one", {62'd0, cnt_a}, 64'd1);
    da = 64'h31; ca = 16'hB1;
    tick();
    check("fl_two", {62'd0, cnt_a}, 64'd2);
    check("fl_stall_pre", {48'd0, st_a}, 64'd4);
    fl_a = 1'b1; da = 64'h32; ca = 16'hB2; rdo_a = 1'b1;
    tick();
    check("fl_valid", {63'd0, vo_a}, 64'd0);
    check("fl_count", {62'd0, cnt_a}, 64'd0);
    check("fl_ctrl", {48'd0, co_a}, 64'd0);
    check("fl_retire", {63'd0, ret_a}, 64'd0);
    check("fl_ready", {63'd0, rdy_a}, 64'd1);
    check("fl_stall", {48'd0, st_a}, 64'd4);
    fl_a = 1'b0; va = 1'b0;
    tick();
    check("fl_discarded", {63'd0, vo_a}, 64'd0);

    // 5. SKID=0 combinational ready
    vb = 1'b1; db = 64'h40; cb = 16'hC0; rdo_b = 1'b0;
    #1;
    check("s0_ready_empty", {63'd0, rdy_b}, 64'd1);
    tick();
    check("s0_valid", {63'd0, vo_b}, 64'd1);
    check("s0_data0", do_b, 64'h40);
    check("s0_ready_low", {63'd0, rdy_b}, 64'd0);
    rdo_b = 1'b1; db = 64'h41;
    #1;
    check("s0_ready_high", {63'd0, rdy_b}, 64'd1);
    tick();
    check("s0_data1", do_b, 64'h41);
    check("s0_ret1", {63'd0, ret_b}, 64'd1);
    db = 64'h42;
    tick();
    check("s0_data2", do_b, 64'h42);
    check("s0_ret2", {63'd0, ret_b}, 64'd1);
    check("s0_count", {62'd0, cnt_b}, 64'd1);
    vb = 1'b0;
    tick();
    check("s0_empty", {62'd0, cnt_b}, 64'd0);

    // 6. Stall counter saturation on the 4-bit instance
    vc = 1'b1; dc = 64'h50; cc = 16'hD0; rdo_c = 1'b0;
    tick();
    vc = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (k == 3 || k == 14 || k == 15 || k == 16 || k == 20)
        check("sat_stall", {60'd0, st_c}, (k < 15) ? 64'(k) : 64'd15);
    end
    check("sat_data_frozen", do_c, 64'h50);

    // Mid-stream reset on A (streaming) and C (stalled)
    va = 1'b1; da = 64'h60; ca = 16'hE0; rdo_a = 1'b1;
    tick();
    da = 64'h61;
    tick();
    rst_n = 1'b0;
    tick();
    check("mrst_a_valid", {63'd0, vo_a}, 64'd0);
    check("mrst_a_count", {62'd0, cnt_a}, 64'd0);
    check("mrst_a_ctrl", {48'd0, co_a}, 64'd0);
    check("mrst_a_retire", {63'd0, ret_a}, 64'd0);
    check("mrst_a_ready", {63'd0, rdy_a}, 64'd1);
    check("mrst_a_stall", {48'd0, st_a}, 64'd0);
    check("mrst_c_valid", {63'd0, vo_c}, 64'd0);
    check("mrst_c_stall", {60'd0, st_c}, 64'd0);
    check("mrst_c_ready", {63'd0, rdy_c}, 64'd1);
    rst_n = 1'b1; va = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
